// File: rtl/bin_to_display_fmt.sv
// Binary (0..9999) to four active-low seven-segment patterns via serial double-dabble.
// Latency 15 clocks from accepted cargar to listo; cargar is dropped (not queued) while ocupado.
module bin_to_display_fmt #(
   parameter bit LEAD_BLANK = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] valor,
   input  logic        cargar,
   input  logic [3:0]  dp_sel,
   output logic        ocupado,
   output logic        listo,
   output logic        desborde,
   output logic [7:0]  salidaDisplay1,
   output logic [7:0]  salidaDisplay2,
   output logic [7:0]  salidaDisplay3,
   output logic [7:0]  salidaDisplay4
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      ENCODE = 2'd2
   } state_t;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   state_t      state, state_nxt;
   logic [13:0] bin_q;
   logic [15:0] bcd_q;
   logic [3:0]  cnt_q;
   logic [3:0]  dp_q;
   logic        ovf_q;

   logic        accept;
   logic        shift_en;
   logic        encode_en;
   logic [15:0] bcd_adj;
   logic [7:0]  pat1, pat2, pat3, pat4;
   logic        blank1, blank2, blank3;

   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cargar) state_nxt = SHIFT;
         SHIFT:   if (cnt_q == 4'd1) state_nxt = ENCODE;
         ENCODE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / strobes ----------------
   always_comb begin
      accept    = 1'b0;
      shift_en  = 1'b0;
      encode_en = 1'b0;
      ocupado   = 1'b1;
      case (state)
         IDLE: begin
            ocupado = 1'b0;
            accept  = cargar;
         end
         SHIFT:   shift_en  = 1'b1;
         ENCODE:  encode_en = 1'b1;
         default: ocupado   = 1'b0;
      endcase
   end

   // Add-3 corrections all look at the pre-shift nibbles of the same cycle.
   assign bcd_adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
                     add3(bcd_q[7:4]),   add3(bcd_q[3:0])};

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
         dp_q  <= '0;
         ovf_q <= 1'b0;
      end else if (accept) begin
         bin_q <= valor;
         bcd_q <= '0;
         cnt_q <= 4'd14;
         dp_q  <= dp_sel;
         ovf_q <= (valor > 14'd9999);
      end else if (shift_en) begin
         {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
         cnt_q          <= cnt_q - 4'd1;
      end
   end

   assign blank1 = LEAD_BLANK && (bcd_q[15:12] == 4'd0);
   assign blank2 = blank1 && (bcd_q[11:8] == 4'd0);
   assign blank3 = blank2 && (bcd_q[7:4]  == 4'd0);

   // Decimal point is applied last so it also lands on blank and dash patterns.
   always_comb begin
      if (ovf_q) begin
         pat1 = SEG_DASH;
         pat2 = SEG_DASH;
         pat3 = SEG_DASH;
         pat4 = SEG_DASH;
      end else begin
         pat1 = blank1 ? SEG_BLANK : seg7(bcd_q[15:12]);
         pat2 = blank2 ? SEG_BLANK : seg7(bcd_q[11:8]);
         pat3 = blank3 ? SEG_BLANK : seg7(bcd_q[7:4]);
         pat4 = seg7(bcd_q[3:0]);
      end
      pat1[7] = pat1[7] & ~dp_q[3];
      pat2[7] = pat2[7] & ~dp_q[2];
      pat3[7] = pat3[7] & ~dp_q[1];
      pat4[7] = pat4[7] & ~dp_q[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         salidaDisplay1 <= SEG_BLANK;
         salidaDisplay2 <= SEG_BLANK;
         salidaDisplay3 <= SEG_BLANK;
         salidaDisplay4 <= SEG_BLANK;
         desborde       <= 1'b0;
         listo          <= 1'b0;
      end else begin
         listo <= encode_en;
         if (encode_en) begin
            salidaDisplay1 <= pat1;
            salidaDisplay2 <= pat2;
            salidaDisplay3 <= pat3;
            salidaDisplay4 <= pat4;
            desborde       <= ovf_q;
         end
      end
   end

endmodule

// File: tb/tb_bin_to_display_fmt.sv
// Scoreboard bench: one instance per LEAD_BLANK setting, shared stimulus, per-instance monitors.
module tb_bin_to_display_fmt;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] valor;
   logic        cargar;
   logic [3:0]  dp_sel;

   logic        ocupado_a, listo_a, desborde_a;
   logic [7:0]  d1_a, d2_a, d3_a, d4_a;
   logic        ocupado_b, listo_b, desborde_b;
   logic [7:0]  d1_b, d2_b, d3_b, d4_b;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] pats;
      logic        ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   typedef struct {
      logic [13:0] v;
      logic [3:0]  dp;
      logic [31:0] exp_lb1;
      logic [31:0] exp_lb0;
      logic        ovf;
      int          intf_at;
   } vec_t;

   always #5 clk = ~clk;

   bin_to_display_fmt #(.LEAD_BLANK(1'b1)) dut (
      .clk(clk), .reset(reset), .valor(valor), .cargar(cargar), .dp_sel(dp_sel),
      .ocupado(ocupado_a), .listo(listo_a), .desborde(desborde_a),
      .salidaDisplay1(d1_a), .salidaDisplay2(d2_a),
      .salidaDisplay3(d3_a), .salidaDisplay4(d4_a)
   );

   bin_to_display_fmt #(.LEAD_BLANK(1'b0)) dut0 (
      .clk(clk), .reset(reset), .valor(valor), .cargar(cargar), .dp_sel(dp_sel),
      .ocupado(ocupado_b), .listo(listo_b), .desborde(desborde_b),
      .salidaDisplay1(d1_b), .salidaDisplay2(d2_b),
      .salidaDisplay3(d3_b), .salidaDisplay4(d4_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor for LEAD_BLANK=1 instance
   logic prev_listo_a = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && listo_a) begin
         check("listo_a_single_cycle", {31'd0, prev_listo_a}, 32'd0);
         if (q_a.size() == 0) begin
            check("listo_a_unexpected", 32'd1, 32'd0);
         end else begin
            e = q_a.pop_front();
            check("patterns_lb1", {d1_a, d2_a, d3_a, d4_a}, e.pats);
            check("desborde_lb1", {31'd0, desborde_a}, {31'd0, e.ovf});
         end
      end
      prev_listo_a = listo_a;
   end

   // Monitor for LEAD_BLANK=0 instance
   logic prev_listo_b = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset && listo_b) begin
         check("listo_b_single_cycle", {31'd0, prev_listo_b}, 32'd0);
         if (q_b.size() == 0) begin
            check("listo_b_unexpected", 32'd1, 32'd0);
         end else begin
            e = q_b.pop_front();
            check("patterns_lb0", {d1_b, d2_b, d3_b, d4_b}, e.pats);
            check("desborde_lb0", {31'd0, desborde_b}, {31'd0, e.ovf});
         end
      end
      prev_listo_b = listo_b;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one conversion; optionally pulse a conflicting cargar at busy cycle intf_at.
   task automatic run(input vec_t t);
      int n;
      logic [31:0] snap;
      logic stable;
      exp_t ea, eb;
      ea.pats = t.exp_lb1; ea.ovf = t.ovf;
      eb.pats = t.exp_lb0; eb.ovf = t.ovf;
      q_a.push_back(ea);
      q_b.push_back(eb);
      valor  = t.v;
      dp_sel = t.dp;
      cargar = 1'b1;
      step();
      cargar = 1'b0;
      valor  = 14'h3FFF;
      dp_sel = 4'b0101;
      snap   = {d1_a, d2_a, d3_a, d4_a};
      stable = 1'b1;
      n = 0;
      while (ocupado_a && n < 40) begin
         n++;
         if ({d1_a, d2_a, d3_a, d4_a} !== snap) stable = 1'b0;
         if (n == t.intf_at) begin
            cargar = 1'b1;
            valor  = 14'd1111;
         end
         step();
         cargar = 1'b0;
      end
      check("ocupado_cycles", n, 15);
      check("outputs_stable_while_busy", {31'd0, stable}, 32'd1);
      repeat (2) step();
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{14'd1234,  4'b0000, 32'hF9A4B099, 32'hF9A4B099, 1'b0, 0};
      vecs[1] = '{14'd0,     4'b0000, 32'hFFFFFFC0, 32'hC0C0C0C0, 1'b0, 0};
      vecs[2] = '{14'd50,    4'b0010, 32'hFFFF12C0, 32'hC0C012C0, 1'b0, 0};
      vecs[3] = '{14'd9999,  4'b0000, 32'h90909090, 32'h90909090, 1'b0, 0};
      vecs[4] = '{14'd10000, 4'b0000, 32'hBFBFBFBF, 32'hBFBFBFBF, 1'b1, 0};
      vecs[5] = '{14'd7,     4'b0000, 32'hFFFFFFF8, 32'hC0C0C0F8, 1'b0, 0};
      vecs[6] = '{14'd4321,  4'b0000, 32'h99B0A4F9, 32'h99B0A4F9, 1'b0, 5};
      vecs[7] = '{14'd3,     4'b1111, 32'h7F7F7F30, 32'h40404030, 1'b0, 0};
      vecs[8] = '{14'd16383, 4'b1000, 32'h3FBFBFBF, 32'h3FBFBFBF, 1'b1, 0};
      vecs[9] = '{14'd8,     4'b0000, 32'hFFFFFF80, 32'hC0C0C080, 1'b0, 0};

      reset  = 1'b1;
      cargar = 1'b0;
      valor  = '0;
      dp_sel = '0;
      repeat (3) step();
      reset = 1'b0;
      step();
      check("reset_patterns", {d1_a, d2_a, d3_a, d4_a}, 32'hFFFFFFFF);
      check("reset_flags", {29'd0, ocupado_a, listo_a, desborde_a}, 32'd0);

      for (int i = 0; i < 9; i++) run(vecs[i]);

      // Abort a conversion of 5555 with reset at busy cycle 8.
      valor  = 14'd5555;
      cargar = 1'b1;
      step();
      cargar = 1'b0;
      repeat (7) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_patterns", {d1_a, d2_a, d3_a, d4_a}, 32'hFFFFFFFF);
      check("abort_flags", {29'd0, ocupado_a, listo_a, desborde_a}, 32'd0);
      repeat (20) step();
      check("abort_no_listo_queue", q_a.size(), 0);

      run(vecs[9]);

      for (int k = 0; k < 50 && (q_a.size() != 0 || q_b.size() != 0); k++) step();
      check("scoreboard_drained_a", q_a.size(), 0);
      check("scoreboard_drained_b", q_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
